// File: rtl/mch_point_feeder.sv
// Initiator side of the MCH point interface: buffers one job of points, streams it, returns the area.
// Optional wait watchdog enabled by defining MCH_FEEDER_TIMEOUT_EN.
module mch_point_feeder #(
  parameter int N_POINTS    = 20,
  parameter int COORD_W     = 8,
  parameter int AREA_W      = 17,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  output logic               full,
  input  logic               start,
  output logic               busy,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  input  logic               Done,
  input  logic [AREA_W-1:0]  area,
  output logic               res_valid,
  output logic [AREA_W-1:0]  res_area,
  output logic               res_timeout
);

  localparam int CNT_W = $clog2(N_POINTS + 1);
  localparam int IDX_W = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_POINTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 8191) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the 13-bit wait counter");
  end

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         wr_cnt;
  logic [IDX_W-1:0]         rd_idx;
  logic                     done_q;
  logic                     wr_ok;
  logic                     capture;
  logic [2*COORD_W-1:0]     buf_q [N_POINTS];

`ifdef MCH_FEEDER_TIMEOUT_EN
  localparam logic [12:0] TO_LAST = 13'(TIMEOUT_CYC - 1);
  logic [12:0] wait_cnt;
  logic        timeout;
  logic        timeout_q;
  assign res_timeout = timeout_q;
`else
  assign res_timeout = 1'b0;
`endif

  assign full = (wr_cnt == FULL_CNT);
  assign busy = (state_q == S_SEND) || (state_q == S_WAIT);

  // Result handshake: res_valid is a single-cycle strobe with no backpressure;
  // res_area/res_timeout are valid in that cycle and res_area holds afterwards.
  always_comb begin
    state_d = state_q;
    wr_ok   = 1'b0;
    capture = 1'b0;
`ifdef MCH_FEEDER_TIMEOUT_EN
    timeout = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        wr_ok = wr_en && !full;
        if (start && full) state_d = S_SEND;
      end
      S_SEND: begin
        if (rd_idx == LAST_IDX) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Edge, not level: a Done left high by the previous job must not finish this one.
        capture = Done && !done_q;
`ifdef MCH_FEEDER_TIMEOUT_EN
        timeout = !capture && (wait_cnt == TO_LAST);
        if (capture || timeout) state_d = S_IDLE;
`else
        if (capture) state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Point storage carries no reset; emptiness is tracked by wr_cnt alone.
  always_ff @(posedge clk) begin
    if (wr_ok) buf_q[wr_cnt] <= {wr_x, wr_y};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wr_cnt    <= '0;
      rd_idx    <= '0;
      X         <= '0;
      Y         <= '0;
      done_q    <= 1'b0;
      res_valid <= 1'b0;
      res_area  <= '0;
`ifdef MCH_FEEDER_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= Done;
      res_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          rd_idx <= '0;
          if (wr_ok) wr_cnt <= wr_cnt + 1'b1;
        end
        S_SEND: begin
          X      <= buf_q[rd_idx][2*COORD_W-1:COORD_W];
          Y      <= buf_q[rd_idx][COORD_W-1:0];
          rd_idx <= rd_idx + 1'b1;
`ifdef MCH_FEEDER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (capture) begin
            res_area  <= area;
            res_valid <= 1'b1;
            wr_cnt    <= '0;
            rd_idx    <= '0;
`ifdef MCH_FEEDER_TIMEOUT_EN
            timeout_q <= 1'b0;
          end else if (timeout) begin
            res_area  <= '0;
            res_valid <= 1'b1;
            timeout_q <= 1'b1;
            wr_cnt    <= '0;
            rd_idx    <= '0;
          end else begin
            wait_cnt  <= wait_cnt + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mch_point_feeder.sv
// Bench for mch_point_feeder: directed job sequence with random points/areas checked
// against a queue model of the point buffer.
module tb_mch_point_feeder;
  localparam int N  = 20;
  localparam int CW = 8;
  localparam int AW = 17;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, start, Done;
  logic [CW-1:0] wr_x, wr_y, X, Y;
  logic [AW-1:0] area, res_area;
  logic          full, busy, res_valid, res_timeout;

  logic [2*CW-1:0] exp_q[$];
  logic [AW-1:0]   exp_area;
  int              n_checks = 0;
  int              n_fail   = 0;

  always #5 clk = ~clk;

  mch_point_feeder #(.N_POINTS(N), .COORD_W(CW), .AREA_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .full(full),
    .start(start), .busy(busy), .X(X), .Y(Y), .Done(Done), .area(area),
    .res_valid(res_valid), .res_area(res_area), .res_timeout(res_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: the buffer keeps the first N points written while idle.
  task automatic write_pt(input logic [CW-1:0] x, input logic [CW-1:0] y, input bit with_start);
    wr_en = 1'b1; wr_x = x; wr_y = y; start = with_start;
    if (exp_q.size() < N) exp_q.push_back({x, y});
    tick();
    wr_en = 1'b0; start = 1'b0;
  endtask

  task automatic write_random(input int cnt);
    for (int i = 0; i < cnt; i++) write_pt(CW'($urandom()), CW'($urandom()), 1'b0);
  endtask

  task automatic start_job();
    bit accepted;
    accepted = (exp_q.size() == N);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(accepted));
  endtask

  task automatic expect_stream();
    for (int k = 0; k < N; k++) begin
      tick();
      check("stream_x", 32'(X), 32'(exp_q[k][2*CW-1:CW]));
      check("stream_y", 32'(Y), 32'(exp_q[k][CW-1:0]));
      check("stream_busy", 32'(busy), 32'd1);
    end
  endtask

  // Holds Done low for 'delay' cycles, then raises it with area_v; expects a capture.
  task automatic finish_done(input logic [AW-1:0] area_v, input int delay);
    for (int d = 0; d < delay; d++) begin
      tick();
      check("wait_hold_x", 32'(X), 32'(exp_q[N-1][2*CW-1:CW]));
      check("wait_no_res", 32'(res_valid), 32'd0);
    end
    Done = 1'b1; area = area_v; exp_area = area_v;
    tick();
    check("res_valid", 32'(res_valid), 32'd1);
    check("res_area", 32'(res_area), 32'(exp_area));
    check("res_timeout", 32'(res_timeout), 32'd0);
    check("busy_at_res", 32'(busy), 32'd0);
    exp_q.delete();
    area = AW'($urandom());
    tick();
    check("res_valid_drop", 32'(res_valid), 32'd0);
    check("full_after_res", 32'(full), 32'd0);
    check("res_area_hold", 32'(res_area), 32'(exp_area));
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; start = 1'b0; Done = 1'b0;
    wr_x = '0; wr_y = '0; area = '0; exp_area = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    check("rst_x", 32'(X), 32'd0);
    check("rst_y", 32'(Y), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_area", 32'(res_area), 32'd0);
    check("rst_res_timeout", 32'(res_timeout), 32'd0);

    // Job 1: x=i, y=2i, Done after 30 cycles with area 0A5F.
    for (int i = 0; i < N; i++) write_pt(CW'(i), CW'(2 * i), 1'b0);
    check("full_at_n", 32'(full), 32'd1);
    start_job();
    expect_stream();
    finish_done(17'h0A5F, 30);

    // Job 2: start at 19 points ignored, write+start at 19 ignored start, overflow write dropped.
    // Done stays high from job 1 and must not complete this job.
    write_random(N - 1);
    start_job();
    check("busy_start_short", 32'(busy), 32'd0);
    write_pt(CW'($urandom()), CW'($urandom()), 1'b1);
    check("busy_write_start", 32'(busy), 32'd0);
    check("full_after_20", 32'(full), 32'd1);
    write_pt(CW'($urandom()), CW'($urandom()), 1'b0);
    check("full_after_21", 32'(full), 32'd1);
    start_job();
    expect_stream();
    for (int d = 0; d < 10; d++) begin
      tick();
      check("stale_done_no_res", 32'(res_valid), 32'd0);
      check("stale_done_busy", 32'(busy), 32'd1);
    end
    Done = 1'b0;
    tick(); tick();
    finish_done(17'h00123, 0);

    // Random jobs with random Done delay and area.
    Done = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      write_random(N);
      start_job();
      expect_stream();
      finish_done(AW'($urandom()), $urandom_range(0, 40));
      Done = 1'b0;
    end

`ifdef MCH_FEEDER_TIMEOUT_EN
    // Done never rises: timeout result at WAIT cycle TO.
    Done = 1'b0;
    tick();
    write_random(N);
    start_job();
    expect_stream();
    for (int d = 0; d < TO - 1; d++) tick();
    check("to_no_res_early", 32'(res_valid), 32'd0);
    tick();
    check("to_res_valid", 32'(res_valid), 32'd1);
    check("to_res_timeout", 32'(res_timeout), 32'd1);
    check("to_res_area", 32'(res_area), 32'd0);
    exp_q.delete();
    tick();
    check("to_full", 32'(full), 32'd0);
    check("to_busy", 32'(busy), 32'd0);
`endif

    // Reset mid-SEND takes effect without a clock edge.
    Done = 1'b0;
    write_random(N);
    start_job();
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    check("arst_x", 32'(X), 32'd0);
    check("arst_y", 32'(Y), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_full", 32'(full), 32'd0);
    check("arst_res_area", 32'(res_area), 32'd0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();

    // Recovery job after reset.
    write_random(N);
    start_job();
    expect_stream();
    finish_done(AW'($urandom()), 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
